// File: rtl/demultiplexor_32_3_buffered.sv
`default_nettype none
//==============================================================================
// Module      : demultiplexor_32_3_buffered
// Description : Routes one word to one of 2**SEL_W channels (or all of them),
//               holding it in a per-channel one-entry buffer until acknowledged.
// Revision    : 1.0 - initial release
//==============================================================================
module demultiplexor_32_3_buffered #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    input  logic [SEL_W-1:0]                  sel,
    input  logic                              bcast,
    output logic [(2**SEL_W)-1:0]             out_valid,
    output logic [(2**SEL_W)*WIDTH-1:0]       out_data,
    input  logic [(2**SEL_W)-1:0]             out_ack,
    output logic [15:0]                       drop_cnt
);

    localparam int C_N     = 2**SEL_W;
    localparam int C_CNT_W = SEL_W + 1;

    logic [C_N-1:0]     r_valid;
    logic [WIDTH-1:0]   r_data [C_N];
    logic [15:0]        r_drop;

    logic [C_N-1:0]     w_free;
    logic [C_N-1:0]     w_target;
    logic [C_N-1:0]     w_load;
    logic [C_N-1:0]     w_spur;
    logic [C_CNT_W-1:0] w_spur_cnt;
    logic [16:0]        w_drop_sum;
    logic [15:0]        w_drop_next;

    // A slot is free if empty or being drained this very cycle.
    assign w_free = ~r_valid | out_ack;

    always_comb begin
        w_target = '0;
        if (bcast) begin
            w_target = '1;
        end else begin
            w_target[sel] = 1'b1;
        end
    end

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            in_ready = bcast ? (&w_free) : w_free[sel];
        end
    end

    assign w_load = w_target & {C_N{in_valid & in_ready}};
    assign w_spur = out_ack & ~r_valid;

    always_comb begin
        w_spur_cnt = '0;
        for (int k = 0; k < C_N; k++) begin
            w_spur_cnt = w_spur_cnt + C_CNT_W'(w_spur[k]);
        end
    end

    assign w_drop_sum  = {1'b0, r_drop} + 17'(w_spur_cnt);
    assign w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    // Load has priority over ack so a simultaneous drain+refill keeps the slot full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_drop  <= '0;
            for (int k = 0; k < C_N; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_drop <= w_drop_next;
            for (int k = 0; k < C_N; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_data[k]  <= in_data;
                end else if (out_ack[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign drop_cnt  = r_drop;

    generate
        for (genvar k = 0; k < C_N; k++) begin : g_out
            assign out_data[k*WIDTH +: WIDTH] = r_data[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_demultiplexor_32_3_buffered.sv
`default_nettype none
//==============================================================================
// Module      : tb_demultiplexor_32_3_buffered
// Description : Directed plus randomized bench against a behavioural channel model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_demultiplexor_32_3_buffered;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [2:0]   sel;
    logic         bcast;
    logic [7:0]   out_valid;
    logic [255:0] out_data;
    logic [7:0]   out_ack;
    logic [15:0]  drop_cnt;

    demultiplexor_32_3_buffered #(.WIDTH(32), .SEL_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .bcast     (bcast),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: eight one-word mailboxes plus a saturating drop tally.
    bit          m_valid [8];
    logic [31:0] m_data  [8];
    int          m_drop = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_ready();
        bit all_free;
        if (reset) return 1'b0;
        if (!bcast) return (!m_valid[sel]) || out_ack[sel];
        all_free = 1'b1;
        for (int k = 0; k < 8; k++)
            if (m_valid[k] && !out_ack[k]) all_free = 1'b0;
        return all_free;
    endfunction

    function automatic logic [7:0] m_valid_vec();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = m_valid[k];
        return v;
    endfunction

    function automatic logic [255:0] m_bus();
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = m_data[k];
        return b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                m_valid[k] = 1'b0;
                m_data[k]  = '0;
            end
            m_drop = 0;
        end else begin
            bit acc;
            int spur;
            acc  = in_valid && m_ready();
            spur = 0;
            for (int k = 0; k < 8; k++) begin
                if (out_ack[k] && !m_valid[k]) spur++;
                if (acc && (bcast || sel == 3'(k))) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = in_data;
                end else if (out_ack[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
            m_drop = (m_drop + spur > 65535) ? 65535 : m_drop + spur;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in_ready", 256'(in_ready), 256'(m_ready()));
            check("cyc_out_valid", 256'(out_valid), 256'(m_valid_vec()));
            check("cyc_out_data", out_data, m_bus());
            check("cyc_drop_cnt", 256'(drop_cnt), 256'(m_drop));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; in_data = '0; sel = '0; bcast = 1'b0; out_ack = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step();
        settle();
        check("reset_in_ready", 256'(in_ready), 256'(0));
        step();
        check("reset_out_valid", 256'(out_valid), 256'(8'h00));
        check("reset_out_data", out_data, 256'(0));
        check("reset_drop_cnt", 256'(drop_cnt), 256'(0));
        reset = 1'b0; in_valid = 1'b0;

        // Single-word route to channel 3, then back-pressure on a second word.
        step();
        in_valid = 1'b1; sel = 3'd3; in_data = 32'hDEADBEEF;
        settle();
        check("t2_ready", 256'(in_ready), 256'(1));
        step();
        in_data = 32'h11111111;
        settle();
        check("t2_valid", 256'(out_valid), 256'(8'h08));
        check("t2_ch3", 256'(out_data[3*32 +: 32]), 256'(32'hDEADBEEF));
        check("t2_blocked", 256'(in_ready), 256'(0));
        step();
        check("t2_ch3_hold", 256'(out_data[3*32 +: 32]), 256'(32'hDEADBEEF));

        // Drain and refill channel 3 in the same cycle.
        in_data = 32'h12345678; out_ack = 8'h08;
        settle();
        check("t3_ready", 256'(in_ready), 256'(1));
        step();
        in_valid = 1'b0; out_ack = 8'h00;
        check("t3_valid", 256'(out_valid), 256'(8'h08));
        check("t3_ch3", 256'(out_data[3*32 +: 32]), 256'(32'h12345678));

        // Broadcast blocked by a full channel 5, released by its ack.
        in_valid = 1'b1; sel = 3'd5; in_data = 32'h55555555; out_ack = 8'h08;
        step();
        out_ack = 8'h00; bcast = 1'b1; in_data = 32'hA5A5A5A5;
        settle();
        check("t4_blocked", 256'(in_ready), 256'(0));
        check("t4_valid_pre", 256'(out_valid), 256'(8'h20));
        step();
        check("t4_ch5_kept", 256'(out_data[5*32 +: 32]), 256'(32'h55555555));
        out_ack = 8'h20;
        settle();
        check("t4_ready", 256'(in_ready), 256'(1));
        step();
        in_valid = 1'b0; bcast = 1'b0; out_ack = 8'h00;
        check("t4_valid_all", 256'(out_valid), 256'(8'hFF));
        check("t4_ch0", 256'(out_data[0 +: 32]), 256'(32'hA5A5A5A5));
        check("t4_ch7", 256'(out_data[7*32 +: 32]), 256'(32'hA5A5A5A5));

        // Spurious acks and drop counter saturation.
        out_ack = 8'hFF;
        step();
        out_ack = 8'h81;
        step();
        out_ack = 8'h00;
        check("t5_drained", 256'(out_valid), 256'(8'h00));
        step();
        check("t5_drop2", 256'(drop_cnt), 256'(2));
        out_ack = 8'hFF;
        repeat (8191) step();
        check("t5_drop_near", 256'(drop_cnt), 256'(16'd65530));
        step();
        check("t5_drop_sat", 256'(drop_cnt), 256'(16'hFFFF));
        step();
        out_ack = 8'h00;
        check("t5_drop_stay", 256'(drop_cnt), 256'(16'hFFFF));

        // Reset with channels 0 and 2 occupied.
        in_valid = 1'b1; sel = 3'd0; in_data = 32'hC0C0C0C0;
        step();
        sel = 3'd2; in_data = 32'hC2C2C2C2;
        step();
        in_valid = 1'b0;
        check("t6_pre", 256'(out_valid), 256'(8'h05));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_valid", 256'(out_valid), 256'(8'h00));
        check("t6_drop", 256'(drop_cnt), 256'(0));
        check("t6_data", out_data, 256'(0));

        // Randomized traffic honouring the hold-while-stalled producer rule.
        for (int i = 0; i < 3000; i++) begin
            bit stall;
            @(negedge clk);
            stall = in_valid && !in_ready;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 299) == 0);
            if (!stall) begin
                in_valid = ($urandom_range(0, 3) != 0);
                sel      = 3'($urandom_range(0, 7));
                bcast    = ($urandom_range(0, 7) == 0);
                in_data  = $urandom;
            end
            out_ack = 8'($urandom & $urandom);
        end
        reset = 1'b0; in_valid = 1'b0; out_ack = 8'h00; bcast = 1'b0;
        step();
        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
